// File: rtl/cardinal_nic.sv
// cardinal_nic: network interface between one cardinal_processor and its
// local NoC router port. The processor sees a four-register window:
// 00 input buffer, 01 input status, 10 output buffer, 11 output status.
// The router side uses a send/ready handshake. Outgoing packets are gated by
// the network polarity bit against packet bit 0 (the VC bit).
// Optional macro NIC_OUT_DEPTH2_EN turns the single output entry into a
// 2-entry FIFO. The default build, with the macro undefined, uses one entry.
// All vectors are big-endian: bit 0 is the MSB.
module cardinal_nic #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:1]            addr,
   input  logic [0:DATA_WIDTH-1] d_in,
   output logic [0:DATA_WIDTH-1] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [0:DATA_WIDTH-1] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [0:DATA_WIDTH-1] net_do,
   input  logic                  net_polarity
);

   logic                  w_rdEn;
   logic                  w_wrEn;
   logic                  w_inPop;
   logic                  w_outWrite;
   logic                  w_send;
   logic                  w_outFullStatus;
   logic [0:DATA_WIDTH-1] w_outHead;

   logic [0:DATA_WIDTH-1] r_inBuf;
   logic                  r_inFull;

   assign w_rdEn  = nicEn & ~nicWrEn;
   assign w_wrEn  = nicEn & nicWrEn;
   assign w_inPop = w_rdEn & (addr == 2'b00) & r_inFull;
   assign net_ri  = ~r_inFull;

   // Capture a router packet when empty; a processor read of 00 frees it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inBuf  <= '0;
         r_inFull <= 1'b0;
      end else if (net_si & ~r_inFull) begin
         r_inBuf  <= net_di;
         r_inFull <= 1'b1;
      end else if (w_inPop) begin
         r_inFull <= 1'b0;
      end
   end

`ifdef NIC_OUT_DEPTH2_EN
   logic [0:DATA_WIDTH-1] r_outMem [0:1];
   logic                  r_wrPtr;
   logic                  r_rdPtr;
   logic [1:0]            r_count;

   assign w_outFullStatus = (r_count == 2'd2);
   assign w_outHead       = r_outMem[r_rdPtr];
   assign w_outWrite      = w_wrEn & (addr == 2'b10) & (r_count != 2'd2);
   assign w_send          = (r_count != 2'd0) & net_ro & (w_outHead[0] == net_polarity);

   // Two-entry output FIFO; a write and a send in one cycle never touch the same slot
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outMem[0] <= '0;
         r_outMem[1] <= '0;
         r_wrPtr     <= 1'b0;
         r_rdPtr     <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         if (w_outWrite) begin
            r_outMem[r_wrPtr] <= d_in;
            r_wrPtr           <= ~r_wrPtr;
         end
         if (w_send) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_outWrite, w_send})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [0:DATA_WIDTH-1] r_outBuf;
   logic                  r_outFull;

   assign w_outFullStatus = r_outFull;
   assign w_outHead       = r_outBuf;
   assign w_outWrite      = w_wrEn & (addr == 2'b10) & ~r_outFull;
   assign w_send          = r_outFull & net_ro & (r_outBuf[0] == net_polarity);

   // Single output entry; a write is only taken when the entry was empty at cycle start
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outBuf  <= '0;
         r_outFull <= 1'b0;
      end else if (w_outWrite) begin
         r_outBuf  <= d_in;
         r_outFull <= 1'b1;
      end else if (w_send) begin
         r_outFull <= 1'b0;
      end
   end
`endif

   assign net_so = w_send;
   assign net_do = w_outHead;

   // Register read mux; status bits land in the LSB (bit DATA_WIDTH-1)
   always_comb begin
      d_out = '0;
      if (w_rdEn) begin
         case (addr)
            2'b00:   d_out = r_inBuf;
            2'b01:   d_out[DATA_WIDTH-1] = r_inFull;
            2'b11:   d_out[DATA_WIDTH-1] = w_outFullStatus;
            default: d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic (both output depth builds).
module tb_cardinal_nic;

   logic        clk;
   logic        reset;
   logic [0:1]  addr;
   logic [0:63] d_in;
   logic [0:63] d_out;
   logic        nicEn;
   logic        nicWrEn;
   logic        net_si;
   logic        net_ri;
   logic [0:63] net_di;
   logic        net_so;
   logic        net_ro;
   logic [0:63] net_do;
   logic        net_polarity;

   int          compareCount = 0;
   int          failCount    = 0;
   logic [63:0] rd;

   cardinal_nic #(.DATA_WIDTH(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and step just past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bus access lasting a single edge; returns d_out sampled before that edge
   task automatic applyStimulus(input logic [1:0] a, input logic wr,
                                input logic [63:0] data, output logic [63:0] rdData);
      addr    = a;
      nicWrEn = wr;
      d_in    = data;
      nicEn   = 1'b1;
      #1;
      rdData  = d_out;
      @(posedge clk);
      #1;
      nicEn   = 1'b0;
      nicWrEn = 1'b0;
      d_in    = '0;
      #1;
   endtask

   // Compare one observation and report any difference
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Directed scenario sequence
   initial begin
      reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
      net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;

      $display("[TB] reset state");
      checkOutput("rst_ri", net_ri, 64'd1);
      checkOutput("rst_so", net_so, 64'd0);
      checkOutput("rst_do", net_do, 64'd0);
      checkOutput("rst_dout", d_out, 64'd0);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("rst_st01", rd, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("rst_st11", rd, 64'd0);

      $display("[TB] receive");
      net_di = 64'h8000_0000_0000_00AA; net_si = 1'b1;
      tick();
      net_si = 1'b0; net_di = '0;
      #1;
      checkOutput("rx_ri_full", net_ri, 64'd0);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("rx_st01_full", rd, 64'd1);
      applyStimulus(2'b00, 1'b0, 64'd0, rd); checkOutput("rx_data", rd, 64'h8000_0000_0000_00AA);
      checkOutput("rx_ri_freed", net_ri, 64'd1);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("rx_st01_empty", rd, 64'd0);
      applyStimulus(2'b00, 1'b0, 64'd0, rd); checkOutput("rx_stale", rd, 64'h8000_0000_0000_00AA);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("rx_stale_st01", rd, 64'd0);

      $display("[TB] offer while full");
      net_di = 64'h0000_0000_0000_00BB; net_si = 1'b1;
      tick();
      net_di = 64'h0000_0000_0000_00CC;
      tick();
      tick();
      net_si = 1'b0; net_di = '0;
      #1;
      applyStimulus(2'b00, 1'b0, 64'd0, rd); checkOutput("rx_hold_first", rd, 64'h0000_0000_0000_00BB);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("rx_hold_st01", rd, 64'd0);

      $display("[TB] send with polarity");
      net_ro = 1'b1; net_polarity = 1'b1;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0055, rd);
      checkOutput("tx_so_wrongpol", net_so, 64'd0);
      checkOutput("tx_do_loaded", net_do, 64'h0000_0000_0000_0055);
      applyStimulus(2'b11, 1'b0, 64'd0, rd);
`ifdef NIC_OUT_DEPTH2_EN
      checkOutput("tx_st11_loaded", rd, 64'd0);
`else
      checkOutput("tx_st11_loaded", rd, 64'd1);
`endif
      checkOutput("tx_so_still_held", net_so, 64'd0);
      net_polarity = 1'b0;
      #1;
      checkOutput("tx_so_match", net_so, 64'd1);
      checkOutput("tx_do_match", net_do, 64'h0000_0000_0000_0055);
      tick();
      checkOutput("tx_so_retired", net_so, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("tx_st11_empty", rd, 64'd0);

      $display("[TB] backpressure");
      net_ro = 1'b0;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0055, rd);
      checkOutput("bp_so_held", net_so, 64'd0);
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0077, rd);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("bp_st11", rd, 64'd1);
      net_ro = 1'b1;
      #1;
      checkOutput("bp_so_release", net_so, 64'd1);
      checkOutput("bp_do_first", net_do, 64'h0000_0000_0000_0055);
      tick();
`ifdef NIC_OUT_DEPTH2_EN
      checkOutput("bp_so_second", net_so, 64'd1);
      checkOutput("bp_do_second", net_do, 64'h0000_0000_0000_0077);
      tick();
`endif
      checkOutput("bp_so_done", net_so, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("bp_st11_empty", rd, 64'd0);

      $display("[TB] write while departing");
      net_ro = 1'b0;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0055, rd);
      net_ro = 1'b1;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0077, rd);
`ifdef NIC_OUT_DEPTH2_EN
      checkOutput("dep_so_next", net_so, 64'd1);
      checkOutput("dep_do_next", net_do, 64'h0000_0000_0000_0077);
      tick();
`endif
      checkOutput("dep_so_after", net_so, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("dep_st11", rd, 64'd0);

      $display("[TB] illegal accesses");
      applyStimulus(2'b00, 1'b1, 64'h0000_0000_0000_0123, rd);
      applyStimulus(2'b11, 1'b1, 64'h0000_0000_0000_0001, rd);
      applyStimulus(2'b01, 1'b1, 64'h0000_0000_0000_0001, rd);
      applyStimulus(2'b10, 1'b0, 64'd0, rd); checkOutput("ill_rd10", rd, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("ill_st11", rd, 64'd0);
      applyStimulus(2'b01, 1'b0, 64'd0, rd); checkOutput("ill_st01", rd, 64'd0);
      checkOutput("ill_ri", net_ri, 64'd1);
      checkOutput("ill_so", net_so, 64'd0);
      applyStimulus(2'b00, 1'b0, 64'd0, rd); checkOutput("ill_inbuf", rd, 64'h0000_0000_0000_00BB);

`ifdef NIC_OUT_DEPTH2_EN
      $display("[TB] two-entry fifo");
      net_ro = 1'b0;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0001, rd);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("f2_st11_one", rd, 64'd0);
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0002, rd);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("f2_st11_two", rd, 64'd1);
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0003, rd);
      net_ro = 1'b1;
      #1;
      checkOutput("f2_so_a", net_so, 64'd1);
      checkOutput("f2_do_a", net_do, 64'h0000_0000_0000_0001);
      tick();
      checkOutput("f2_so_b", net_so, 64'd1);
      checkOutput("f2_do_b", net_do, 64'h0000_0000_0000_0002);
      tick();
      checkOutput("f2_so_done", net_so, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("f2_st11_empty", rd, 64'd0);
`endif

      $display("[TB] reset mid-transfer");
      net_ro = 1'b0;
      applyStimulus(2'b10, 1'b1, 64'h0000_0000_0000_0099, rd);
      net_di = 64'h8000_0000_0000_00DD; net_si = 1'b1;
      tick();
      net_si = 1'b0; net_di = '0;
      #1;
      checkOutput("mid_ri_pre", net_ri, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0; net_ro = 1'b1;
      #1;
      checkOutput("mid_so", net_so, 64'd0);
      checkOutput("mid_do", net_do, 64'd0);
      checkOutput("mid_ri", net_ri, 64'd1);
      applyStimulus(2'b00, 1'b0, 64'd0, rd); checkOutput("mid_inbuf", rd, 64'd0);
      applyStimulus(2'b11, 1'b0, 64'd0, rd); checkOutput("mid_st11", rd, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between one cardinal_processor and its local NoC router port. It exposes a four-register window on the processor's nicEn/nicWrEn/nic_addr/d_out/nic_data bus. It sequences packet transfer through two channels: router to input buffer to processor, and processor to output buffer to router. The router side uses a send/ready handshake gated by the network polarity bit.

## Interface
Parameters:
- DATA_WIDTH, 64, packet and register width; bit 0 is MSB and carries the packet VC bit.

Ports (bit ranges big-endian, [0:N-1]):
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  DATA_WIDTH  processor write data (processor d_out).
- d_out  output  DATA_WIDTH  read data to processor (processor nic_data).
- nicEn  input  1  register access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_si  input  1  router offers packet on net_di.
- net_ri  output  1  NIC can accept a packet.
- net_di  input  DATA_WIDTH  packet from router.
- net_so  output  1  NIC presents packet on net_do.
- net_ro  input  1  router can accept a packet.
- net_do  output  DATA_WIDTH  packet to router.
- net_polarity  input  1  current network phase (even = 0, odd = 1).

## Operation
- State: in_buf, in_full; out_buf, out_full (per output entry, see Configuration).
- Input channel:
  - net_ri = ~in_full.
  - On an edge with net_si & net_ri: in_buf <= net_di, in_full <= 1.
- Processor read (nicEn & ~nicWrEn), combinational d_out:
  - 00: in_buf.
  - 01: {63'b0, in_full}.
  - 10: all zeros.
  - 11: {63'b0, out_full}.
  - No read in progress: d_out = 0.
- Reading 00 with in_full = 1 clears in_full at that edge. Reading 00 while empty returns stale in_buf and changes no state.
- Processor write (nicEn & nicWrEn):
  - Only addr 10 is writable. Writes to 00, 01 and 11 are ignored.
  - Write to 10 with out_full = 0 (value at start of cycle): out_buf <= d_in, out_full <= 1.
  - Write to 10 with out_full = 1 is dropped, even if the head packet departs that same cycle. Software polls 11 before writing.
- Output channel:
  - net_do = head out_buf.
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity), combinational.
  - On an edge with net_so: head entry retires.
- Simultaneous events:
  - Router delivery and processor read of 00 cannot both complete in one cycle, because net_ri = 0 while full.
  - Send and an accepted write never target the same entry.

## Timing
- Reset (synchronous): in_full = 0, out_full = 0, in_buf = 0, out_buf = 0. Hence net_ri = 1, net_so = 0, net_do = 0, d_out = 0 (absent a read).
- Reset mid-transfer discards buffered packets. The router side observes net_so = 0 in the cycle after the reset edge.
- Input latency: packet accepted at edge N is readable via 00 in cycle N+1. Status 01 reads 1 in that cycle.
- Output latency: write at edge N makes net_so eligible in cycle N+1, waiting for net_ro and matching polarity.
- Polarity mismatch holds the packet, so at least one extra cycle when polarity toggles each cycle.

## Configuration
- Macro NIC_OUT_DEPTH2_EN.
- Undefined: single output entry, as described above.
- Defined:
  - Output channel becomes a 2-entry FIFO with a 1-bit pointer pair and count 0..2.
  - Status 11 reads 1 only when count = 2.
  - A write is accepted when the count is below 2 at the start of the cycle.
  - The send condition uses the head entry's bit 0.
  - A send and an accepted write in the same cycle leave count unchanged.
  - Wrap-around of the pointers is modulo 2.
- Input channel unaffected.

## Test plan
- Reset: hold reset 3 cycles, release. Requires net_ri = 1, net_so = 0, and reads of 01 and 11 return 0.
- Receive: net_si = 1, net_di = 64'h8000_0000_0000_00AA.
  - Next cycle: net_ri = 0, read 01 = 1, read 00 = 64'h8000_0000_0000_00AA.
  - After the read edge: 01 = 0, net_ri = 1.
- Send with polarity: write 10 with 64'h0000_0000_0000_0055, net_ro = 1, net_polarity = 1. Requires net_so = 0 until polarity = 0, then net_so = 1 for one cycle with net_do = 64'h...0055, then 11 = 0.
- Backpressure: net_ro = 0 with packet loaded.
  - Requires net_so held 0 and 11 = 1.
  - A second write of 64'h...0077 is dropped.
  - After net_ro = 1, only 64'h...0055 is sent.
- Illegal accesses: write 00 and 11, read 10. Requires no state change and read of 10 = 0.
- NIC_OUT_DEPTH2_EN: write 64'h...0001 then 64'h...0002 with net_ro = 0.
  - Requires 11 = 1 after the second write, and a third write is dropped.
  - Release net_ro with matching polarity: net_do shows 0001 then 0002 in order.
